qn_cau_pipe: RTL and testbench
==============================

// Module: qn_cau_pipe
// PURPOSE
//  N-lane complex add/sub/accumulate unit for the QFT datapath, successor to the 2-lane register-feedback CAU.
//  Per lane: computes A+B, A-B, acc+B or acc-B on signed complex operands.
//  Optional saturation and optional per-component |x|.
//  2-stage pipeline with valid/ready on both sides; per-beat and sticky overflow flags.
// PARAMETERS
//  DATA_W  32  signed two's-complement width of each real/imag component
//  LANES   2   number of parallel complex lanes (>=1)
//  SAT     1   1: saturate on overflow; 0: wrap (two's complement)
// PORTS
//  clk        in   1                  clock; all logic on rising edge
//  rst        in   1                  synchronous, active-high reset
//  in_valid   in   1                  input beat valid
//  in_ready   out  1                  input beat accepted when in_valid&in_ready
//  op         in   2                  00 ADD A+B, 01 SUB A-B, 10 ACC acc+B, 11 ACCS acc-B
//  abs        in   1                  1: output |re|,|im| per component
//  A_r,A_i    in   DATA_W x LANES     operand A (ignored for ACC/ACCS)
//  B_r,B_i    in   DATA_W x LANES     operand B
//  acc_clr    in   1                  zero all lane accumulators
//  out_valid  out  1                  result beat valid
//  out_ready  in   1                  result consumed when out_valid&out_ready
//  S_r,S_i    out  DATA_W x LANES     result
//  overflow   out  1                  OR of all overflow events of the current output beat
//  ovf_sticky out  1                  set by any consumed overflowing beat; held until cleared
//  ovf_clr    in   1                  clears ovf_sticky
// BEHAVIOUR
//  Reset: in_ready=0 during rst, then 1; out_valid=0; S_r/S_i=0; overflow=0; ovf_sticky=0; acc=0.
//    In-flight beats are dropped.
//  Handshake:
//    adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1.
//    out_valid=v2; outputs stable while out_valid&!out_ready.
//  Latency: 2 cycles accept->out_valid with no stall. Throughput 1 beat/cycle. Order preserved; no loss/dup.
//  Stage 1 (on accept):
//    X = A (ADD/SUB) or acc[lane] (ACC/ACCS); per component DATA_W+1-bit X+/-B.
//    Reduce to DATA_W: out-of-range -> sat to +max/-min (SAT=1) or truncate (SAT=0); ovf1 flagged.
//    Register result, ovf1, abs.
//  Accumulator: acc[lane] <= stage-1 DATA_W result on every accepted beat, any op, pre-abs.
//    Back-to-back ACC chains without bubbles.
//    acc_clr with accepted ACC/ACCS beat in same cycle: beat uses acc=0; acc then takes beat result.
//    acc_clr alone: acc=0.
//  Stage 2: if abs, negate negative components.
//    |-2^(DATA_W-1)| -> 2^(DATA_W-1)-1 with ovf2 if SAT=1; if SAT=0, stays -2^(DATA_W-1) with ovf2.
//    overflow = OR(ovf1,ovf2) over all lanes/components; registered alongside S.
//  Sticky: set on out_valid&out_ready&overflow.
//    ovf_clr same cycle as set -> set wins.
//    rst overrides all.
//  Stall: held stages keep data; acc not updated by stalled beats (only on accept).
// STRUCTURE
//  Package qcau_pkg: typedef enum logic[1:0] cau_op_e {OP_ADD,OP_SUB,OP_ACC,OP_ACCS};
//    function sat_narrow(DATA_W+1 -> DATA_W, SAT) returning value+ovf.
//  Sub-module cau_lane_sat: one lane; stage-1 datapath, acc register, stage-2 abs.
//  Top: handshake/valid control, LANES x generate, overflow OR, sticky flag.
// TESTING (DATA_W=8, LANES=2, SAT=1 unless noted)
//  1 ADD A=(3,-4),B=(5,2), out_ready=1 -> S=(8,-2) 2 cycles after accept, overflow=0.
//  2 SUB A_r=100,B_r=-100 -> S_r=127, overflow=1, ovf_sticky=1; SAT=0 -> S_r=-56, overflow=1.
//  3 acc_clr, then 3 back-to-back ACC B=(10,-1) -> (10,-1),(20,-2),(30,-3) on consecutive cycles.
//  4 ADD abs=1: A=(-128,-5),B=0 -> S=(127,5), overflow=1.
//  5 Offer 4 beats, out_ready=0 for 3 cycles -> in_ready drops after 2 accepts; 4 results in order, none lost/duplicated.
//  6 rst mid-stream -> out_valid=0, acc=0 next cycle; ovf_clr concurrent with overflowing handshake -> ovf_sticky=1.

Source files
------------

// File: rtl/qcau_pkg.sv
// Shared types and the widen-then-narrow helper for the complex add/sub/accumulate unit.
package qcau_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_ACCS = 2'b11
    } cau_op_e;

    localparam int unsigned MAX_W = 64;
    localparam int unsigned EXT_W = MAX_W + 1;

    typedef struct packed {
        logic [MAX_W-1:0] val;
        logic             ovf;
    } narrow_t;

    // Narrow a sign-extended (w+1)-bit value to w bits; only val[w-1:0] is meaningful.
    function automatic narrow_t sat_narrow(
        input logic [EXT_W-1:0] x,
        input int unsigned      w,
        input logic             sat
    );
        narrow_t          r;
        logic [EXT_W-1:0] hi;
        logic [MAX_W-1:0] lim;
        hi    = $signed(x) >>> (w - 1);
        lim   = MAX_W'(1) << (w - 1);
        r.ovf = !((hi == '0) || (hi == '1));
        if (r.ovf && sat) begin
            r.val = x[MAX_W] ? lim : (lim - MAX_W'(1));
        end else begin
            r.val = x[MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/cau_lane_sat.sv
// One complex lane: stage-1 add/sub with narrowing, lane accumulator, and the
// combinational stage-2 magnitude path feeding the top-level output register.
module cau_lane_sat
    import qcau_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter bit          SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept_i,
    input  logic [1:0]        op_i,
    input  logic              abs_i,
    input  logic              acc_clr_i,
    input  logic [DATA_W-1:0] a_r_i,
    input  logic [DATA_W-1:0] a_i_i,
    input  logic [DATA_W-1:0] b_r_i,
    input  logic [DATA_W-1:0] b_i_i,
    output logic [DATA_W-1:0] s_r_c_o,
    output logic [DATA_W-1:0] s_i_c_o,
    output logic              ovf_c_o
);

    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_V = ~MIN_V;

    // Returns {ovf, result} of x +/- b reduced back to DATA_W bits.
    function automatic logic [DATA_W:0] add_sub(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] b,
        input logic              sub
    );
        logic [EXT_W-1:0] xe;
        logic [EXT_W-1:0] be;
        narrow_t          n;
        xe = EXT_W'($signed(x));
        be = EXT_W'($signed(b));
        n  = sat_narrow(sub ? (xe - be) : (xe + be), DATA_W, SAT);
        return {n.ovf, n.val[DATA_W-1:0]};
    endfunction

    // Returns {ovf, |v|}; the most negative value has no positive counterpart.
    function automatic logic [DATA_W:0] abs_fix(input logic [DATA_W-1:0] v);
        if (!v[DATA_W-1]) begin
            return {1'b0, v};
        end
        if (v == MIN_V) begin
            return {1'b1, (SAT ? MAX_V : MIN_V)};
        end
        return {1'b0, ({DATA_W{1'b0}} - v)};
    endfunction

    cau_op_e           op_e;
    logic              use_acc;
    logic              sub;
    logic [DATA_W-1:0] x_r;
    logic [DATA_W-1:0] x_i;
    logic [DATA_W:0]   n_r;
    logic [DATA_W:0]   n_i;
    logic [DATA_W:0]   f_r;
    logic [DATA_W:0]   f_i;
    logic [DATA_W-1:0] res_r_d;
    logic [DATA_W-1:0] res_i_d;
    logic              ovf1_d;

    logic [DATA_W-1:0] acc_r_q;
    logic [DATA_W-1:0] acc_i_q;
    logic [DATA_W-1:0] res_r_q;
    logic [DATA_W-1:0] res_i_q;
    logic              ovf1_q;
    logic              abs_q;

    assign op_e    = cau_op_e'(op_i);
    assign use_acc = (op_e == OP_ACC) || (op_e == OP_ACCS);
    assign sub     = (op_e == OP_SUB) || (op_e == OP_ACCS);

    // Stage 1: a concurrent acc_clr makes an accumulate beat start from zero.
    always_comb begin
        x_r = a_r_i;
        x_i = a_i_i;
        if (use_acc) begin
            x_r = acc_clr_i ? '0 : acc_r_q;
            x_i = acc_clr_i ? '0 : acc_i_q;
        end
        n_r     = add_sub(x_r, b_r_i, sub);
        n_i     = add_sub(x_i, b_i_i, sub);
        res_r_d = n_r[DATA_W-1:0];
        res_i_d = n_i[DATA_W-1:0];
        ovf1_d  = n_r[DATA_W] | n_i[DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r_q <= '0;
            acc_i_q <= '0;
            res_r_q <= '0;
            res_i_q <= '0;
            ovf1_q  <= 1'b0;
            abs_q   <= 1'b0;
        end else if (accept_i) begin
            res_r_q <= res_r_d;
            res_i_q <= res_i_d;
            ovf1_q  <= ovf1_d;
            abs_q   <= abs_i;
            acc_r_q <= res_r_d;
            acc_i_q <= res_i_d;
        end else if (acc_clr_i) begin
            acc_r_q <= '0;
            acc_i_q <= '0;
        end
    end

    // Stage 2 next-value: optional per-component magnitude.
    always_comb begin
        f_r     = abs_fix(res_r_q);
        f_i     = abs_fix(res_i_q);
        s_r_c_o = res_r_q;
        s_i_c_o = res_i_q;
        ovf_c_o = ovf1_q;
        if (abs_q) begin
            s_r_c_o = f_r[DATA_W-1:0];
            s_i_c_o = f_i[DATA_W-1:0];
            ovf_c_o = ovf1_q | f_r[DATA_W] | f_i[DATA_W];
        end
    end

endmodule

// File: rtl/qn_cau_pipe.sv
// N-lane complex add/sub/accumulate unit: two-stage valid/ready pipeline,
// per-beat overflow and a sticky overflow flag.
module qn_cau_pipe
    import qcau_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 2,
    parameter bit          SAT    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              op,
    input  logic                    abs,
    input  logic [LANES*DATA_W-1:0] A_r,
    input  logic [LANES*DATA_W-1:0] A_i,
    input  logic [LANES*DATA_W-1:0] B_r,
    input  logic [LANES*DATA_W-1:0] B_i,
    input  logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] S_r,
    output logic [LANES*DATA_W-1:0] S_i,
    output logic                    overflow,
    output logic                    ovf_sticky,
    input  logic                    ovf_clr
);

    localparam int unsigned BUS_W = LANES * DATA_W;

    logic             adv1;
    logic             adv2;
    logic             accept;
    logic [BUS_W-1:0] s_r_c;
    logic [BUS_W-1:0] s_i_c;
    logic [LANES-1:0] lane_ovf_c;
    logic             sticky_d;

    logic             v1_q;
    logic             v2_q;
    logic [BUS_W-1:0] s_r_q;
    logic [BUS_W-1:0] s_i_q;
    logic             ovf_q;
    logic             sticky_q;

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = !rst && adv1;
    assign accept   = in_valid && in_ready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        cau_lane_sat #(
            .DATA_W (DATA_W),
            .SAT    (SAT)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .accept_i  (accept),
            .op_i      (op),
            .abs_i     (abs),
            .acc_clr_i (acc_clr),
            .a_r_i     (A_r[l*DATA_W +: DATA_W]),
            .a_i_i     (A_i[l*DATA_W +: DATA_W]),
            .b_r_i     (B_r[l*DATA_W +: DATA_W]),
            .b_i_i     (B_i[l*DATA_W +: DATA_W]),
            .s_r_c_o   (s_r_c[l*DATA_W +: DATA_W]),
            .s_i_c_o   (s_i_c[l*DATA_W +: DATA_W]),
            .ovf_c_o   (lane_ovf_c[l])
        );
    end

    // A consumed overflowing beat wins over a concurrent clear.
    always_comb begin
        sticky_d = sticky_q;
        if (v2_q && out_ready && ovf_q) begin
            sticky_d = 1'b1;
        end else if (ovf_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            s_r_q    <= '0;
            s_i_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (adv1) begin
                v1_q <= accept;
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    s_r_q <= s_r_c;
                    s_i_q <= s_i_c;
                    ovf_q <= |lane_ovf_c;
                end
            end
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = v2_q;
    assign S_r        = s_r_q;
    assign S_i        = s_i_q;
    assign overflow   = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_qn_cau_pipe.sv
// Bench for qn_cau_pipe: a saturating and a wrapping instance share stimulus and
// are compared against an integer-arithmetic model with an in-order scoreboard.
module tb_qn_cau_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  op;
    logic        abs;
    logic [15:0] A_r, A_i, B_r, B_i;
    logic        acc_clr;
    logic        out_ready;
    logic        ovf_clr;

    logic        in_ready_s, out_valid_s, ovf_s, sticky_s;
    logic [15:0] S_r_s, S_i_s;
    logic        in_ready_w, out_valid_w, ovf_w, sticky_w;
    logic [15:0] S_r_w, S_i_w;

    always #5 clk = ~clk;

    qn_cau_pipe #(.DATA_W(8), .LANES(2), .SAT(1'b1)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .op(op), .abs(abs), .A_r(A_r), .A_i(A_i), .B_r(B_r), .B_i(B_i),
        .acc_clr(acc_clr), .out_valid(out_valid_s), .out_ready(out_ready),
        .S_r(S_r_s), .S_i(S_i_s), .overflow(ovf_s), .ovf_sticky(sticky_s),
        .ovf_clr(ovf_clr)
    );

    qn_cau_pipe #(.DATA_W(8), .LANES(2), .SAT(1'b0)) u_dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .op(op), .abs(abs), .A_r(A_r), .A_i(A_i), .B_r(B_r), .B_i(B_i),
        .acc_clr(acc_clr), .out_valid(out_valid_w), .out_ready(out_ready),
        .S_r(S_r_w), .S_i(S_i_w), .overflow(ovf_w), .ovf_sticky(sticky_w),
        .ovf_clr(ovf_clr)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          n_acc  = 0;
    int          macc [2][2][2];   // [sat][re/im][lane]
    logic [32:0] q_s[$];           // {S_r, S_i, overflow}
    logic [32:0] q_w[$];
    int          qt[$];            // accept cycle of each outstanding beat
    bit          st_s, st_w;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int lane_val(input logic [15:0] v, input int l);
        logic [7:0] t;
        t = 8'(v >> (8 * l));
        return int'($signed(t));
    endfunction

    function automatic void clear_acc();
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int l = 0; l < 2; l++)
                    macc[s][c][l] = 0;
    endfunction

    // Expected output beat for the current inputs; updates the model accumulators.
    function automatic logic [32:0] model_beat(input bit sat);
        logic [15:0] er, ei;
        bit          o;
        int          s, x, b, v, r, y;
        s  = sat ? 1 : 0;
        o  = 1'b0;
        er = '0;
        ei = '0;
        for (int l = 0; l < 2; l++) begin
            for (int c = 0; c < 2; c++) begin
                if (op[1]) x = acc_clr ? 0 : macc[s][c][l];
                else       x = lane_val(c == 0 ? A_r : A_i, l);
                b = lane_val(c == 0 ? B_r : B_i, l);
                v = op[0] ? x - b : x + b;
                if (v > 127) begin
                    o = 1'b1;
                    r = sat ? 127 : v - 256;
                end else if (v < -128) begin
                    o = 1'b1;
                    r = sat ? -128 : v + 256;
                end else begin
                    r = v;
                end
                macc[s][c][l] = r;
                y = r;
                if (abs && r < 0) begin
                    if (r == -128) begin
                        o = 1'b1;
                        y = sat ? 127 : -128;
                    end else begin
                        y = -r;
                    end
                end
                if (c == 0) er[8*l +: 8] = 8'(y);
                else        ei[8*l +: 8] = 8'(y);
            end
        end
        return {er, ei, o};
    endfunction

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic step();
        bit          rdy, ov, hs;
        logic [32:0] es, ew;
        #1;
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready_s), 32'd0);
            q_s.delete();
            q_w.delete();
            qt.delete();
            clear_acc();
            st_s = 1'b0;
            st_w = 1'b0;
        end else begin
            rdy = (q_s.size() < 2) || out_ready;
            ov  = 1'b0;
            if (qt.size() > 0) ov = (cyc - qt[0]) >= 2;
            chk("in_ready", 32'(in_ready_s), 32'(rdy));
            chk("in_ready_wrap", 32'(in_ready_w), 32'(rdy));
            chk("out_valid", 32'(out_valid_s), 32'(ov));
            chk("out_valid_wrap", 32'(out_valid_w), 32'(ov));
            chk("sticky", 32'(sticky_s), 32'(st_s));
            chk("sticky_wrap", 32'(sticky_w), 32'(st_w));
            hs = ov && out_ready;
            if (hs) begin
                es = q_s.pop_front();
                ew = q_w.pop_front();
                void'(qt.pop_front());
                chk("S_r", 32'(S_r_s), 32'(es[32:17]));
                chk("S_i", 32'(S_i_s), 32'(es[16:1]));
                chk("overflow", 32'(ovf_s), 32'(es[0]));
                chk("S_r_wrap", 32'(S_r_w), 32'(ew[32:17]));
                chk("S_i_wrap", 32'(S_i_w), 32'(ew[16:1]));
                chk("overflow_wrap", 32'(ovf_w), 32'(ew[0]));
                if (es[0]) st_s = 1'b1; else if (ovf_clr) st_s = 1'b0;
                if (ew[0]) st_w = 1'b1; else if (ovf_clr) st_w = 1'b0;
            end else if (ovf_clr) begin
                st_s = 1'b0;
                st_w = 1'b0;
            end
            if (in_valid && rdy) begin
                q_s.push_back(model_beat(1'b1));
                q_w.push_back(model_beat(1'b0));
                qt.push_back(cyc);
                n_acc++;
            end else if (acc_clr) begin
                clear_acc();
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_data();
        A_r = 16'($urandom);
        A_i = 16'($urandom);
        B_r = 16'($urandom);
        B_i = 16'($urandom);
    endtask

    initial begin
        int base, prev;
        rst = 1'b1; in_valid = 1'b0; op = 2'd0; abs = 1'b0; acc_clr = 1'b0;
        out_ready = 1'b1; ovf_clr = 1'b0;
        A_r = '0; A_i = '0; B_r = '0; B_i = '0;
        clear_acc();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid_s), 32'd0);
        chk("reset_S_r", 32'(S_r_s), 32'd0);
        chk("reset_S_i", 32'(S_i_s), 32'd0);
        chk("reset_overflow", 32'(ovf_s), 32'd0);
        chk("reset_sticky", 32'(sticky_s), 32'd0);

        // ADD (3,-4)+(5,2)
        in_valid = 1'b1; op = 2'd0;
        A_r = 16'h0003; A_i = 16'h00FC; B_r = 16'h0005; B_i = 16'h0002;
        step();
        in_valid = 1'b0;
        step();
        chk("t1_valid", 32'(out_valid_s), 32'd1);
        chk("t1_S_r", 32'(S_r_s[7:0]), 32'h08);
        chk("t1_S_i", 32'(S_i_s[7:0]), 32'hFE);
        chk("t1_ovf", 32'(ovf_s), 32'd0);
        step();

        // SUB 100 - (-100)
        in_valid = 1'b1; op = 2'd1;
        A_r = 16'h0064; A_i = 16'h0000; B_r = 16'h009C; B_i = 16'h0000;
        step();
        in_valid = 1'b0;
        step();
        chk("t2_S_r_sat", 32'(S_r_s[7:0]), 32'h7F);
        chk("t2_S_r_wrap", 32'(S_r_w[7:0]), 32'hC8);
        chk("t2_ovf_sat", 32'(ovf_s), 32'd1);
        chk("t2_ovf_wrap", 32'(ovf_w), 32'd1);
        step();
        chk("t2_sticky", 32'(sticky_s), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;

        // acc_clr then three back-to-back ACC of (10,-1)
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        in_valid = 1'b1; op = 2'd2;
        B_r = 16'h0A0A; B_i = 16'hFFFF;
        step();
        step();
        step();
        in_valid = 1'b0;
        chk("t3_S_r_2nd", 32'(S_r_s[7:0]), 32'h14);
        chk("t3_S_i_2nd", 32'(S_i_s[7:0]), 32'hFE);
        step();
        step();

        // ADD with abs: (-128,-5)+0
        in_valid = 1'b1; op = 2'd0; abs = 1'b1;
        A_r = 16'h0080; A_i = 16'h00FB; B_r = 16'h0000; B_i = 16'h0000;
        step();
        in_valid = 1'b0;
        step();
        chk("t4_S_r_sat", 32'(S_r_s[7:0]), 32'h7F);
        chk("t4_S_i_sat", 32'(S_i_s[7:0]), 32'h05);
        chk("t4_S_r_wrap", 32'(S_r_w[7:0]), 32'h80);
        chk("t4_ovf", 32'(ovf_s), 32'd1);
        step();
        abs = 1'b0;

        // Four beats offered into a stalled output
        base = n_acc;
        prev = -1;
        in_valid = 1'b1; op = 2'd0;
        for (int k = 0; k < 30 && n_acc < base + 4; k++) begin
            out_ready = (k >= 3);
            if (n_acc != prev) begin
                rand_data();
                prev = n_acc;
            end
            step();
            if (k == 2) chk("t5_two_accepts", 32'(n_acc - base), 32'd2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("t5_drained", 32'(q_s.size()), 32'd0);

        // Reset mid-stream, accumulator restart, sticky set beats clear
        in_valid = 1'b1; op = 2'd2;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            step();
        end
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        chk("t6_rst_out_valid", 32'(out_valid_s), 32'd0);
        in_valid = 1'b1; op = 2'd2; B_r = 16'h0101; B_i = 16'h0101;
        step();
        in_valid = 1'b0;
        step();
        chk("t6_acc_zero_S_r", 32'(S_r_s), 32'h0101);
        step();
        in_valid = 1'b1; op = 2'd1;
        A_r = 16'h0064; A_i = 16'h0000; B_r = 16'h009C; B_i = 16'h0000;
        step();
        in_valid = 1'b0;
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t6_sticky_set_wins", 32'(sticky_s), 32'd1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 2'($urandom);
            abs       = ($urandom_range(0, 3) == 0);
            acc_clr   = ($urandom_range(0, 9) == 0);
            ovf_clr   = ($urandom_range(0, 9) == 0);
            rand_data();
            step();
        end
        in_valid = 1'b0; acc_clr = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("final_drained", 32'(q_s.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
